// File: rtl/serial_frame_rx_if.sv
// Bundle of the serial receiver's line input and its parallel word/status outputs.
interface serial_frame_rx_if #(
  parameter int unsigned DATA_W = 8
);
  logic              sin;
  logic [DATA_W-1:0] dout;
  logic              dvalid;
  logic              ferr;
  logic              busy;

  modport master (output sin, input dout, dvalid, ferr, busy);
  modport slave  (input sin, output dout, dvalid, ferr, busy);
endinterface

// File: rtl/serial_frame_rx.sv
// Start/data/stop serial receiver: synchronises the line, samples each bit at mid-period,
// and reports good words (dvalid) or a low stop bit (ferr) with one-cycle strobes.
module serial_frame_rx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_W       = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_frame_rx_if.slave bus
);

  localparam int unsigned     CntW     = $clog2(CLKS_PER_BIT);
  localparam int unsigned     IdxW     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(DATA_W - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;

  state_e              state_q, state_d;
  logic                sync1_q, sync2_q;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                dvalid_q, dvalid_d;
  logic                ferr_q, ferr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Synchroniser resets to the idle (high) line level so reset never looks like a start bit.
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      sync1_q  <= bus.sin;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      ferr_q   <= ferr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CntW'(1);
    idx_d    = idx_q;
    shift_d  = shift_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    ferr_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!sync2_q) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          if (!sync2_q) begin
            state_d = StData;
            idx_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[DATA_W-1:1]};
          if (idx_q == IdxLast) begin
            state_d = StStop;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (sync2_q) begin
            dout_d   = shift_q;
            dvalid_d = 1'b1;
            state_d  = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StWaitHigh;
          end
        end
      end
      StWaitHigh: begin
        // A line stuck low must go high before another start can be seen.
        cnt_d = '0;
        if (sync2_q) state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  assign bus.dout   = dout_q;
  assign bus.dvalid = dvalid_q;
  assign bus.ferr   = ferr_q;
  assign bus.busy   = (state_q != StIdle);

endmodule
